// File: rtl/axi_arb_pkg.sv
// Shared definitions for the two-master AXI-lite arbiter.
//   arb_state_e : arbiter FSM state encoding
//   MST_IFU/LSU : master identifiers, as stored in the read-owner register
//   OKAY..DECERR: AXI response codes (responses pass through unmodified)
package axi_arb_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_AR   = 3'd1,
      RD_R    = 3'd2,
      WR_AW_W = 3'd3,
      WR_B    = 3'd4
   } arb_state_e;

   localparam logic MST_IFU = 1'b0;
   localparam logic MST_LSU = 1'b1;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] EXOKAY = 2'b01;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axi_arb_grant.sv
// Read-grant picker for the two masters.
// Build option: ARB_RR_EN
//   defined   : round-robin; the master granted last loses the next tie.
//               clk/rst/grant_i exist only in this build.
//   undefined : fixed priority, LSU over IFU; purely combinational.
// Ports:
//   req0_i  : IFU read request       req1_i : LSU read request
//   grant_i : a read is granted this cycle (advances the RR pointer)
//   pick_o  : selected master (MST_IFU / MST_LSU)
//   any_o   : at least one read request pending
import axi_arb_pkg::*;

module axi_arb_grant (
`ifdef ARB_RR_EN
   input  logic clk,
   input  logic rst,
   input  logic grant_i,
`endif
   input  logic req0_i,
   input  logic req1_i,
   output logic pick_o,
   output logic any_o
);

   assign any_o = req0_i | req1_i;

`ifdef ARB_RR_EN
   logic last_q, last_d;

   // Last granted master; reset to LSU so the IFU wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_q <= MST_LSU;
      else     last_q <= last_d;
   end

   always_comb begin
      pick_o = req1_i ? MST_LSU : MST_IFU;
      if (req0_i && req1_i) pick_o = ~last_q;
      last_d = last_q;
      if (grant_i) last_d = pick_o;
   end
`else
   assign pick_o = req1_i ? MST_LSU : MST_IFU;
`endif

endmodule

// File: rtl/axi_lite_arbiter.sv
// Two-master (IFU read-only, LSU read/write), one-slave AXI-lite arbiter.
// One transaction at a time; writes win over reads; responses are routed
// combinationally to the owning master, non-owners see valid/ready low.
// Build option: ARB_RR_EN selects round-robin read arbitration
// (see axi_arb_grant); undefined gives LSU-over-IFU fixed priority.
// Ports:
//   clk, rst          : clock, async active-high reset
//   m0_ar*/m0_r*      : IFU read channels
//   m1_ar*/m1_r*      : LSU read channels
//   m1_aw*/m1_w*/m1_b*: LSU write channels
//   s_*               : slave port towards ram_axi_lite
import axi_arb_pkg::*;

module axi_lite_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int STRB_W = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_arvalid,
   input  logic [ADDR_W-1:0] m0_araddr,
   output logic              m0_arready,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [1:0]        m0_rresp,
   input  logic              m0_rready,
   input  logic              m1_arvalid,
   input  logic [ADDR_W-1:0] m1_araddr,
   output logic              m1_arready,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [1:0]        m1_rresp,
   input  logic              m1_rready,
   input  logic              m1_awvalid,
   input  logic [ADDR_W-1:0] m1_awaddr,
   output logic              m1_awready,
   input  logic              m1_wvalid,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic [STRB_W-1:0] m1_wstrb,
   output logic              m1_wready,
   output logic              m1_bvalid,
   output logic [1:0]        m1_bresp,
   input  logic              m1_bready,
   output logic              s_arvalid,
   output logic [ADDR_W-1:0] s_araddr,
   input  logic              s_arready,
   input  logic              s_rvalid,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic [1:0]        s_rresp,
   output logic              s_rready,
   output logic              s_awvalid,
   output logic [ADDR_W-1:0] s_awaddr,
   input  logic              s_awready,
   output logic              s_wvalid,
   output logic [DATA_W-1:0] s_wdata,
   output logic [STRB_W-1:0] s_wstrb,
   input  logic              s_wready,
   input  logic              s_bvalid,
   input  logic [1:0]        s_bresp,
   output logic              s_bready
);

   arb_state_e state_q, state_d;
   logic       owner_q, owner_d;
   logic       aw_done_q, aw_done_d;
   logic       w_done_q, w_done_d;
   logic       rd_pick, rd_any, rd_grant;

   axi_arb_grant u_grant (
`ifdef ARB_RR_EN
      .clk     (clk),
      .rst     (rst),
      .grant_i (rd_grant),
`endif
      .req0_i  (m0_arvalid),
      .req1_i  (m1_arvalid),
      .pick_o  (rd_pick),
      .any_o   (rd_any)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         owner_q   <= MST_IFU;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      aw_done_d  = aw_done_q;
      w_done_d   = w_done_q;
      rd_grant   = 1'b0;
      m0_arready = 1'b0;
      m0_rvalid  = 1'b0;
      m0_rdata   = '0;
      m0_rresp   = '0;
      m1_arready = 1'b0;
      m1_rvalid  = 1'b0;
      m1_rdata   = '0;
      m1_rresp   = '0;
      m1_awready = 1'b0;
      m1_wready  = 1'b0;
      m1_bvalid  = 1'b0;
      m1_bresp   = '0;
      s_arvalid  = 1'b0;
      s_araddr   = '0;
      s_rready   = 1'b0;
      s_awvalid  = 1'b0;
      s_awaddr   = '0;
      s_wvalid   = 1'b0;
      s_wdata    = '0;
      s_wstrb    = '0;
      s_bready   = 1'b0;

      unique case (state_q)
         IDLE: begin
            // A complete write request beats every read, including m1's own.
            if (m1_awvalid && m1_wvalid) begin
               state_d = WR_AW_W;
            end else if (rd_any) begin
               state_d  = RD_AR;
               owner_d  = rd_pick;
               rd_grant = 1'b1;
            end
         end
         RD_AR: begin
            if (owner_q == MST_LSU) begin
               s_arvalid  = m1_arvalid;
               s_araddr   = m1_araddr;
               m1_arready = s_arready;
            end else begin
               s_arvalid  = m0_arvalid;
               s_araddr   = m0_araddr;
               m0_arready = s_arready;
            end
            if (s_arvalid && s_arready) state_d = RD_R;
         end
         RD_R: begin
            if (owner_q == MST_LSU) begin
               m1_rvalid = s_rvalid;
               m1_rdata  = s_rdata;
               m1_rresp  = s_rresp;
               s_rready  = m1_rready;
            end else begin
               m0_rvalid = s_rvalid;
               m0_rdata  = s_rdata;
               m0_rresp  = s_rresp;
               s_rready  = m0_rready;
            end
            if (s_rvalid && s_rready) state_d = IDLE;
         end
         WR_AW_W: begin
            // Each channel's valid drops once it has handshaken, so AW and W
            // may complete in either order without a duplicate transfer.
            s_awvalid  = m1_awvalid & ~aw_done_q;
            s_awaddr   = m1_awaddr;
            m1_awready = s_awready & ~aw_done_q;
            s_wvalid   = m1_wvalid & ~w_done_q;
            s_wdata    = m1_wdata;
            s_wstrb    = m1_wstrb;
            m1_wready  = s_wready & ~w_done_q;
            aw_done_d  = aw_done_q | (s_awvalid & s_awready);
            w_done_d   = w_done_q | (s_wvalid & s_wready);
            if (aw_done_d && w_done_d) state_d = WR_B;
         end
         WR_B: begin
            m1_bvalid = s_bvalid;
            m1_bresp  = s_bresp;
            s_bready  = m1_bready;
            if (s_bvalid && s_bready) begin
               state_d   = IDLE;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter with a queue-based scoreboard.
// Expectations are pushed at stimulus time; a negedge monitor pops and
// compares on every handshake seen on the slave AR/AW/W and master R/B.
import axi_arb_pkg::*;

module tb_axi_lite_arbiter;

   localparam int AW = 64;
   localparam int DW = 64;
   localparam int SW = 8;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [1:0]    r;
   } rsp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_arvalid, m0_arready, m0_rvalid, m0_rready;
   logic [AW-1:0] m0_araddr;
   logic [DW-1:0] m0_rdata;
   logic [1:0]    m0_rresp;
   logic          m1_arvalid, m1_arready, m1_rvalid, m1_rready;
   logic [AW-1:0] m1_araddr;
   logic [DW-1:0] m1_rdata;
   logic [1:0]    m1_rresp;
   logic          m1_awvalid, m1_awready, m1_wvalid, m1_wready;
   logic [AW-1:0] m1_awaddr;
   logic [DW-1:0] m1_wdata;
   logic [SW-1:0] m1_wstrb;
   logic          m1_bvalid, m1_bready;
   logic [1:0]    m1_bresp;
   logic          s_arvalid, s_arready, s_rvalid, s_rready;
   logic [AW-1:0] s_araddr;
   logic [DW-1:0] s_rdata;
   logic [1:0]    s_rresp;
   logic          s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
   logic [AW-1:0] s_awaddr;
   logic [DW-1:0] s_wdata;
   logic [SW-1:0] s_wstrb;
   logic [1:0]    s_bresp;

   always #5 clk = ~clk;

   axi_lite_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STRB_W(SW)) dut (
      .clk(clk), .rst(rst),
      .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arready(m0_arready),
      .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rready(m0_rready),
      .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arready(m1_arready),
      .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rready(m1_rready),
      .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awready(m1_awready),
      .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wready(m1_wready),
      .m1_bvalid(m1_bvalid), .m1_bresp(m1_bresp), .m1_bready(m1_bready),
      .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
      .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
      .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
      .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
      .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready)
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic [AW-1:0]    exp_ar[$];
   logic [AW-1:0]    exp_aw[$];
   logic [DW+SW-1:0] exp_w[$];
   logic [1:0]       exp_b[$];
   rsp_t             exp_r0[$];
   rsp_t             exp_r1[$];

   int ar_cnt = 0;
   int aw_cnt = 0;
   int w_cnt  = 0;

   // slave knobs
   int         aw_lat  = 0;
   int         w_lat   = 0;
   logic [1:0] rresp_k = OKAY;
   logic [1:0] bresp_k = OKAY;

   function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endfunction

   function automatic void unexp(input string nm, input logic [127:0] act);
      n_chk++;
      n_fail++;
      $display("FAIL %s: unexpected handshake, got %0h, required none", nm, act);
   endfunction

   function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
      case (a)
         64'h8000_0000: mem = 64'h0010_0073;
         64'h8000_1000: mem = 64'h1234_5678;
         default:       mem = a ^ 64'h5A5A_5A5A_A5A5_A5A5;
      endcase
   endfunction

   function automatic logic [20:0] outs_v();
      outs_v = {m0_arready, m0_rvalid, |m0_rdata, |m0_rresp, m1_arready, m1_rvalid,
                |m1_rdata, |m1_rresp, m1_awready, m1_wready, m1_bvalid, |m1_bresp,
                s_arvalid, |s_araddr, s_rready, s_awvalid, |s_awaddr, s_wvalid,
                |s_wdata, |s_wstrb, s_bready};
   endfunction

   // scoreboard monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (s_arvalid && s_arready) begin
            ar_cnt++;
            if (exp_ar.size() == 0) unexp("s_ar", s_araddr);
            else chk("s_araddr", s_araddr, exp_ar.pop_front());
         end
         if (s_awvalid && s_awready) begin
            aw_cnt++;
            if (exp_aw.size() == 0) unexp("s_aw", s_awaddr);
            else chk("s_awaddr", s_awaddr, exp_aw.pop_front());
         end
         if (s_wvalid && s_wready) begin
            w_cnt++;
            if (exp_w.size() == 0) unexp("s_w", {s_wdata, s_wstrb});
            else chk("s_wdata_strb", {s_wdata, s_wstrb}, exp_w.pop_front());
         end
         if (m0_rvalid && m0_rready) begin
            if (exp_r0.size() == 0) unexp("m0_r", {m0_rdata, m0_rresp});
            else chk("m0_rdata_resp", {m0_rdata, m0_rresp}, exp_r0.pop_front());
         end
         if (m1_rvalid && m1_rready) begin
            if (exp_r1.size() == 0) unexp("m1_r", {m1_rdata, m1_rresp});
            else chk("m1_rdata_resp", {m1_rdata, m1_rresp}, exp_r1.pop_front());
         end
         if (m1_bvalid && m1_bready) begin
            if (exp_b.size() == 0) unexp("m1_b", m1_bresp);
            else chk("m1_bresp", m1_bresp, exp_b.pop_front());
         end
         if (m0_rvalid || m1_rvalid) chk("rvalid_exclusive", m0_rvalid & m1_rvalid, 0);
      end
   end

   // behavioural slave: AR always ready, R one cycle after AR, AW/W ready after
   // a programmable number of waiting cycles, B one cycle after both accepted
   initial begin : slave
      logic ar_h, r_h, aw_h, w_h, b_h, aw_got, w_got;
      logic [AW-1:0] ar_a;
      int aw_wait, w_wait;
      s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = '0;
      s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = '0;
      aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0; ar_a = '0;
      forever begin
         @(negedge clk);
         ar_h = s_arvalid && s_arready;
         r_h  = s_rvalid && s_rready;
         aw_h = s_awvalid && s_awready;
         w_h  = s_wvalid && s_wready;
         b_h  = s_bvalid && s_bready;
         if (ar_h) ar_a = s_araddr;
         if (s_awvalid && !aw_h) aw_wait++;
         if (s_wvalid && !w_h) w_wait++;
         @(posedge clk);
         #1;
         if (rst) begin
            s_rvalid = 0; s_bvalid = 0; aw_got = 0; w_got = 0;
            aw_wait = 0; w_wait = 0; s_arready = 0;
         end else begin
            if (r_h) s_rvalid = 0;
            if (ar_h) begin
               s_rvalid = 1; s_rdata = mem(ar_a); s_rresp = rresp_k;
            end
            s_arready = 1;
            if (aw_h) begin aw_got = 1; aw_wait = 0; end
            if (w_h) begin w_got = 1; w_wait = 0; end
            if (b_h) s_bvalid = 0;
            if (aw_got && w_got) begin
               s_bvalid = 1; s_bresp = bresp_k; aw_got = 0; w_got = 0;
            end
            s_awready = (aw_wait >= aw_lat);
            s_wready  = (w_wait >= w_lat);
         end
      end
   end

   task automatic rd(input logic m, input logic [AW-1:0] a, output int lat);
      int c;
      bit rh, drop;
      if (m) begin m1_arvalid = 1; m1_araddr = a; end
      else begin m0_arvalid = 1; m0_araddr = a; end
      c = 0; rh = 0;
      while (!rh && c < 100) begin
         @(negedge clk);
         c++;
         drop = m ? (m1_arvalid && m1_arready) : (m0_arvalid && m0_arready);
         rh   = m ? (m1_rvalid && m1_rready) : (m0_rvalid && m0_rready);
         @(posedge clk);
         #1;
         if (drop) begin
            if (m) m1_arvalid = 0; else m0_arvalid = 0;
         end
      end
      chk(m ? "m1_read_done" : "m0_read_done", rh, 1);
      lat = c;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                     output int ar_at_b, output int aw_c, output int w_c);
      int c;
      bit awh, wh, bh;
      m1_awvalid = 1; m1_awaddr = a; m1_wvalid = 1; m1_wdata = d; m1_wstrb = s;
      c = 0; bh = 0; ar_at_b = -1; aw_c = -1; w_c = -1;
      while (!bh && c < 100) begin
         @(negedge clk);
         c++;
         awh = m1_awvalid && m1_awready;
         wh  = m1_wvalid && m1_wready;
         if (awh) aw_c = c;
         if (wh) w_c = c;
         if (m1_bvalid && m1_bready) begin bh = 1; ar_at_b = ar_cnt; end
         @(posedge clk);
         #1;
         if (awh) m1_awvalid = 0;
         if (wh) m1_wvalid = 0;
      end
      chk("write_done", bh, 1);
   endtask

   task automatic pulse_rst();
      rst = 1;
      @(posedge clk);
      @(negedge clk);
      #2 rst = 0;
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int l0, l1, lx, ar0, ar_b, aw_c, w_c, aw0, w0, c;

   initial begin : stim
      rst = 1;
      m0_arvalid = 0; m0_araddr = '0; m0_rready = 1;
      m1_arvalid = 0; m1_araddr = '0; m1_rready = 1;
      m1_awvalid = 0; m1_awaddr = '0; m1_wvalid = 0; m1_wdata = '0; m1_wstrb = '0;
      m1_bready = 1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs_zero", outs_v(), 0);
      @(negedge clk);
      #2 rst = 0;
      @(posedge clk);
      #1;

      // single IFU read, 3 cycles, s_arvalid at N+1, m1 untouched
      exp_ar.push_back(64'h8000_0000);
      exp_r0.push_back('{d: 64'h0010_0073, r: OKAY});
      fork
         rd(1'b0, 64'h8000_0000, l0);
         begin
            @(negedge clk); chk("s_arvalid_cycleN", s_arvalid, 0);
            chk("m1_rvalid_quiet0", m1_rvalid, 0);
            @(negedge clk); chk("s_arvalid_cycleN1", s_arvalid, 1);
            chk("m1_rvalid_quiet1", m1_rvalid, 0);
            @(negedge clk); chk("m1_rvalid_quiet2", m1_rvalid, 0);
         end
      join
      chk("read_latency", l0, 3);

      // simultaneous reads, two rounds, from a fresh reset
      pulse_rst();
      for (int r = 0; r < 2; r++) begin
`ifdef ARB_RR_EN
         exp_ar.push_back(64'h8000_0000);
         exp_ar.push_back(64'h8000_1000);
`else
         exp_ar.push_back(64'h8000_1000);
         exp_ar.push_back(64'h8000_0000);
`endif
         exp_r0.push_back('{d: 64'h0010_0073, r: OKAY});
         exp_r1.push_back('{d: 64'h1234_5678, r: OKAY});
         fork
            rd(1'b0, 64'h8000_0000, l0);
            rd(1'b1, 64'h8000_1000, l1);
         join
      end

      // LSU write, W accepted two cycles before AW
      aw_lat = 2; w_lat = 0;
      aw0 = aw_cnt; w0 = w_cnt;
      exp_aw.push_back(64'h8000_2000);
      exp_w.push_back({64'hDEAD_BEEF, 8'h0F});
      exp_b.push_back(OKAY);
      wr(64'h8000_2000, 64'hDEAD_BEEF, 8'h0F, ar_b, aw_c, w_c);
      chk("aw_handshakes", aw_cnt - aw0, 1);
      chk("w_handshakes", w_cnt - w0, 1);
      chk("w_before_aw_by_2", aw_c - w_c, 2);
      aw_lat = 0;

      // write + both reads at once: write first, then read arbitration
      ar0 = ar_cnt;
      exp_aw.push_back(64'h8000_3000);
      exp_w.push_back({64'h0123_4567_89AB_CDEF, 8'hFF});
      exp_b.push_back(OKAY);
`ifdef ARB_RR_EN
      exp_ar.push_back(64'h8000_5000);
      exp_ar.push_back(64'h8000_4000);
`else
      exp_ar.push_back(64'h8000_4000);
      exp_ar.push_back(64'h8000_5000);
`endif
      exp_r0.push_back('{d: 64'h8000_5000 ^ 64'h5A5A_5A5A_A5A5_A5A5, r: OKAY});
      exp_r1.push_back('{d: 64'h8000_4000 ^ 64'h5A5A_5A5A_A5A5_A5A5, r: OKAY});
      fork
         wr(64'h8000_3000, 64'h0123_4567_89AB_CDEF, 8'hFF, ar_b, aw_c, w_c);
         rd(1'b1, 64'h8000_4000, l1);
         rd(1'b0, 64'h8000_5000, l0);
      join
      chk("no_read_before_write_b", ar_b, ar0);
      chk("aw_w_same_cycle", aw_c, w_c);

      // SLVERR forwarded unchanged, then a normal read still takes 3 cycles
      rresp_k = SLVERR;
      exp_ar.push_back(64'h8000_0000);
      exp_r0.push_back('{d: 64'h0010_0073, r: SLVERR});
      rd(1'b0, 64'h8000_0000, lx);
      rresp_k = OKAY;
      exp_ar.push_back(64'h8000_1000);
      exp_r0.push_back('{d: 64'h1234_5678, r: OKAY});
      rd(1'b0, 64'h8000_1000, lx);
      chk("read_latency_after_slverr", lx, 3);

      // reset while in RD_R with rready withheld
      m0_rready = 0;
      exp_ar.push_back(64'h8000_6000);
      m0_arvalid = 1; m0_araddr = 64'h8000_6000;
      c = 0;
      while (m0_arvalid && c < 20) begin
         @(negedge clk);
         c++;
         if (m0_arready) begin
            @(posedge clk);
            #1 m0_arvalid = 0;
         end
      end
      chk("rst_test_ar_accepted", m0_arvalid, 0);
      c = 0;
      @(negedge clk);
      while (!m0_rvalid && c < 20) begin
         @(negedge clk);
         c++;
      end
      chk("rst_test_in_rd_r", m0_rvalid, 1);
      rst = 1;
      #1;
      chk("midrst_outputs_zero", outs_v(), 0);
      @(posedge clk);
      @(negedge clk);
      #2 rst = 0;
      m0_rready = 1;
      @(posedge clk);
      #1;
      exp_ar.push_back(64'h8000_7000);
      exp_r0.push_back('{d: 64'h8000_7000 ^ 64'h5A5A_5A5A_A5A5_A5A5, r: OKAY});
      rd(1'b0, 64'h8000_7000, lx);
      chk("read_latency_after_rst", lx, 3);

      repeat (3) @(posedge clk);
      chk("exp_ar_left", exp_ar.size(), 0);
      chk("exp_r0_left", exp_r0.size(), 0);
      chk("exp_r1_left", exp_r1.size(), 0);
      chk("exp_aw_left", exp_aw.size(), 0);
      chk("exp_w_left", exp_w.size(), 0);
      chk("exp_b_left", exp_b.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_lite_arbiter.md
# axi_lite_arbiter

Two-master, one-slave AXI-lite arbiter that shares the single `ram_axi_lite` port between the IFU (read-only, instruction fetch) and the LSU (data reads and writes). It sits between `IFU`/the load-store path and `ram_axi_lite` in `top`. It grants one transaction at a time, routes the slave's response back to the owning master, and holds the slave port idle otherwise.

## Interface
Parameters:
- `ADDR_W`, default 64: address width; equals `MemAddrBus`.
- `DATA_W`, default 64: data width; equals `MemDataBus`.
- `STRB_W`, default `DATA_W/8`: write-strobe width.

Ports:
- `clk`  in  1  single clock; everything is sampled on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `m0_arvalid`/`m0_araddr`  in  1/`ADDR_W`  IFU read request.
- `m0_arready`  out  1  IFU read-address accept.
- `m0_rvalid`/`m0_rdata`/`m0_rresp`  out  1/`DATA_W`/2  IFU read response.
- `m0_rready`  in  1  IFU response accept.
- `m1_arvalid`/`m1_araddr`, `m1_arready`, `m1_rvalid`/`m1_rdata`/`m1_rresp`, `m1_rready`: LSU read channels, same widths and directions as the m0 read signals.
- `m1_awvalid`/`m1_awaddr`  in  1/`ADDR_W`  LSU write address; `m1_awready`  out  1.
- `m1_wvalid`/`m1_wdata`/`m1_wstrb`  in  1/`DATA_W`/`STRB_W`  LSU write data; `m1_wready`  out  1.
- `m1_bvalid`/`m1_bresp`  out  1/2  LSU write response; `m1_bready`  in  1.
- `s_*`: slave side, the full AR/R/AW/W/B set with mirrored directions, connected to `ram_axi_lite`.

## Operation
- FSM states: `IDLE`, `RD_AR`, `RD_R`, `WR_AW_W`, `WR_B`. A 1-bit register `owner` records which master holds the read grant.
- In `IDLE`, requests are sampled:
  - `m1_awvalid` and `m1_wvalid` both high → `WR_AW_W`. Writes take priority over every read, including m1's own `arvalid`.
  - Otherwise any `arvalid` → `RD_AR`, with `owner` set by the grant policy (see Configuration).
- `RD_AR`:
  - `s_arvalid`/`s_araddr` are driven from the owner; `s_arready` is returned to the owner only.
  - On the handshake → `RD_R`.
- `RD_R`:
  - `s_rvalid`, `s_rdata` and `s_rresp` are routed to the owner; `s_rready` comes from the owner.
  - On the handshake → `IDLE`.
- `WR_AW_W`:
  - AW and W are forwarded together. Sticky flags `aw_done` and `w_done` mask each channel's valid after its own handshake.
  - When both are done → `WR_B`.
- `WR_B`: B is forwarded to m1; on the handshake → `IDLE` and both flags clear.
- Non-owning masters always see ready=0 and valid=0. All data and response buses pass through unmodified; SLVERR and DECERR are forwarded as-is.
- Masters must hold valid and payload stable until the handshake (AXI rule). The arbiter does not latch request payloads.

## Timing
- Reset: state=`IDLE`, `owner`=m0, both done flags 0, RR pointer set so that m0 wins the first tie. Every valid/ready output is 0. Data outputs are don't-care, driven 0.
- A request seen in `IDLE` at cycle N makes `s_arvalid` (or `s_awvalid`/`s_wvalid`) high at N+1. The arbitration cost is 1 cycle.
- A read with a slave that is ready immediately takes 3 cycles: `IDLE` → `RD_AR` → `RD_R`.
- Back-to-back transactions always pass through 1 `IDLE` cycle.
- AW and W may handshake in the same cycle or in either order.
- Response paths are combinational from `s_*` to `m*_*`. There is no added latency once a transaction is granted.
- Asserting `rst` mid-transaction returns to `IDLE` immediately and drops all valids/readies. Any in-flight slave transaction is abandoned, and `ram_axi_lite` is reset by the same `rst`.

## Configuration
- `ARB_RR_EN` defined: round-robin between m0 and m1 reads. The master granted last loses the next tie; the pointer updates only on a granted read.
- `ARB_RR_EN` undefined: fixed priority for reads, m1 (LSU) over m0 (IFU).
- Write priority over reads is the same in both builds.

## Structure
- Package `axi_arb_pkg` holds:
  - the FSM state encoding;
  - `MST_IFU=1'b0` and `MST_LSU=1'b1`;
  - the AXI response constants `OKAY`, `EXOKAY`, `SLVERR`, `DECERR`.
- Sub-module `axi_arb_grant`: combinational 2-way pick plus the RR pointer register, holding all of the `ARB_RR_EN` logic. The rest is a single FSM and the muxes.

## Test plan
- Single IFU read of 0x80000000, slave returns 0x00100073: `m0_rdata`=0x00100073 with `m0_rresp`=0. `m1_rvalid` stays 0 throughout. Total 3 cycles from request to handshake.
- m0 and m1 `arvalid` raised in the same cycle, addresses 0x80000000 and 0x80001000:
  - with `ARB_RR_EN` undefined, m1 is served first, then m0;
  - with `ARB_RR_EN` defined, m0 is served first after reset, then m1, then m0 on the next tie.
- LSU write to 0x80002000, data 0xDEADBEEF, wstrb 0x0F, slave accepts W 2 cycles before AW: exactly one `s_wvalid` and one `s_awvalid` handshake, then `m1_bvalid`=1 with bresp 0.
- m1 asserts `awvalid`, `wvalid` and `arvalid` together while m0 also requests: the write completes first, then the read arbitration proceeds.
- Slave returns `rresp`=2'b10 on an IFU read: forwarded unchanged as `m0_rresp`=2'b10, and the FSM returns to `IDLE`.
- `rst` pulsed during `RD_R` while `s_rready` is withheld: all outputs 0 in the same cycle, state=`IDLE`, and the next request is granted normally after release.
